// File: rtl/comparador_serial.sv
// comparador_serial: bit-serial unsigned magnitude comparator, MSB first.
//
// A start accepted while not busy loads both operands. The block then
// consumes one bit pair per clock, and on the last bit it publishes a
// two-bit result code and pulses done for one cycle.
// Result codes: 01 = A == B, 10 = A > B, 11 = A < B, 00 = no result since reset.
//
// Optional feature (macro COMPARADOR_EARLY_EXIT_EN): the operation completes
// on the first differing bit instead of always running WIDTH cycles.
//
// Ports:
//   clk    in   1      clock, all state updates on the rising edge
//   rst    in   1      synchronous active-high reset
//   start  in   1      load a_in/b_in and start a comparison (ignored while busy)
//   a_in   in   WIDTH  operand A, unsigned
//   b_in   in   WIDTH  operand B, unsigned
//   busy   out  1      comparison in progress
//   done   out  1      one-cycle pulse, res valid
//   res    out  2      result code, held until next completion or reset
module comparador_serial #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [1:0]       res
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_FIN  = 2'b10;

  localparam logic [1:0] CMP_EQ = 2'b01;
  localparam logic [1:0] CMP_GT = 2'b10;
  localparam logic [1:0] CMP_LT = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [1:0]       cmp_q, cmp_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       res_q, res_d;

  logic             a_bit_c;
  logic             b_bit_c;
  logic [1:0]       cmp_next_c;
  logic             finish_c;

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cmp_q   <= CMP_EQ;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cmp_q   <= cmp_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_q   <= res_d;
    end
  end

  // Per-bit comparison step; GT/LT are absorbing once reached
  always_comb begin
    a_bit_c    = a_q[WIDTH-1];
    b_bit_c    = b_q[WIDTH-1];
    cmp_next_c = cmp_q;
    if (cmp_q == CMP_EQ) begin
      if (a_bit_c == b_bit_c) begin
        cmp_next_c = CMP_EQ;
      end else if (a_bit_c) begin
        cmp_next_c = CMP_GT;
      end else begin
        cmp_next_c = CMP_LT;
      end
    end
  end

  // Completion condition for the current RUN edge
  always_comb begin
    finish_c = (cnt_q == CW'(1));
`ifdef COMPARADOR_EARLY_EXIT_EN
    // Leaving the equal state decides the result, so stop right there
    if ((cmp_q == CMP_EQ) && (cmp_next_c != CMP_EQ)) begin
      finish_c = 1'b1;
    end
`endif
  end

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    cmp_d   = cmp_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    res_d   = res_q;

    case (state_q)
      ST_IDLE, ST_FIN: begin
        // FIN accepts start directly, giving back-to-back operation
        if (start) begin
          state_d = ST_RUN;
          a_d     = a_in;
          b_d     = b_in;
          cmp_d   = CMP_EQ;
          cnt_d   = CW'(WIDTH);
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      ST_RUN: begin
        cmp_d = cmp_next_c;
        a_d   = a_q << 1;
        b_d   = b_q << 1;
        cnt_d = cnt_q - CW'(1);
        if (finish_c) begin
          state_d = ST_FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          res_d   = cmp_next_c;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign res  = res_q;

endmodule

// File: tb/tb_comparador_serial.sv
// Self-checking bench for comparador_serial (WIDTH = 8): directed cases
// followed by randomized operands, checked against an arithmetic model.
module tb_comparador_serial;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [1:0]       res;

  int n_vec;
  int n_err;
  logic [1:0] exp_res;

  comparador_serial #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .res   (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; sample and drive 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference result from plain unsigned arithmetic
  function automatic logic [1:0] model_res(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (a == b) return 2'b01;
    else if (a > b) return 2'b10;
    else return 2'b11;
  endfunction

  // Cycles from acceptance to done
  function automatic int model_lat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef COMPARADOR_EARLY_EXIT_EN
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (a[i] != b[i]) return WIDTH - i;
    end
    return WIDTH;
`else
    return WIDTH;
`endif
  endfunction

  // mode: 0 start low during run, 1 start held high, 2 random start,
  //       3 single start pulse sampled at edge k+3. Operands are scrambled
  //       after acceptance in every mode.
  task automatic run_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int mode);
    int lat;
    logic [1:0] r;
    lat = model_lat(a, b);
    r   = model_res(a, b);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    step();
    chk("accept_busy", busy, 1);
    chk("accept_done", done, 0);
    for (int i = 1; i <= lat; i++) begin
      a_in = WIDTH'($urandom);
      b_in = WIDTH'($urandom);
      case (mode)
        1:       start = 1'b1;
        2:       start = 1'($urandom);
        3:       start = (i == 3);
        default: start = 1'b0;
      endcase
      step();
      if (i < lat) begin
        chk("run_busy", busy, 1);
        chk("run_done", done, 0);
        chk("run_res_held", res, exp_res);
      end else begin
        chk("fin_done", done, 1);
        chk("fin_busy", busy, 0);
        chk("fin_res", res, r);
      end
    end
    start   = 1'b0;
    exp_res = r;
  endtask

  task automatic idle_chk(input string tag);
    step();
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_res"}, res, exp_res);
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    n_vec   = 0;
    n_err   = 0;
    exp_res = 2'b00;
    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    step();
    step();
    rst = 1'b0;

    // Reset state and idle behaviour
    for (int i = 0; i < 3; i++) idle_chk("reset_idle");

    // Equal, greater (MSB differs), less (LSB differs, start pulse ignored)
    run_cmp(8'hA5, 8'hA5, 0);
    idle_chk("post_eq");
    run_cmp(8'h80, 8'h7F, 0);
    idle_chk("post_gt");
    run_cmp(8'h12, 8'h13, 3);
    idle_chk("post_lt");

    // Back-to-back: second start accepted in the FIN cycle
    run_cmp(8'h01, 8'h00, 1);
    run_cmp(8'h00, 8'h01, 1);
    idle_chk("post_b2b");

    // Reset at edge k+4 aborts the comparison
    start = 1'b1;
    a_in  = 8'hFF;
    b_in  = 8'h00;
    step();
    start = 1'b0;
    for (int i = 1; i <= 3; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_res = 2'b00;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_res", res, 0);
    idle_chk("abort_idle");

    // Reset wins over start at the same edge
    rst   = 1'b1;
    start = 1'b1;
    a_in  = 8'h33;
    b_in  = 8'h44;
    step();
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_prio_busy", busy, 0);
    chk("rst_prio_res", res, 0);
    idle_chk("rst_prio_idle");

    // Randomized operands, a quarter of them equal
    for (int n = 0; n < 40; n++) begin
      ra = WIDTH'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : WIDTH'($urandom);
      run_cmp(ra, rb, int'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) idle_chk("rand_idle");
    end
    idle_chk("final_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
